// File: rtl/bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_arb_pkg
// Description : Shared definitions for the two-requester BRAM arbiter.
//               Holds the FSM state encoding, the default BRAM word-address
//               width and the address range helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_arb_pkg;

  // Default BRAM word-address width.
  localparam int unsigned N_DEFAULT = 17;

  // Transaction FSM encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Mask that keeps the low n bits of a 32-bit word address.
  function automatic logic [31:0] addr_mask(input int unsigned n);
    if (n >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << n) - 32'd1;
  endfunction

  // True when any address bit at or above bit n is set.
  function automatic logic addr_oob(input logic [31:0] addr, input int unsigned n);
    if (n >= 32) begin
      return 1'b0;
    end
    return |(addr >> n);
  endfunction

endpackage : bram_arb_pkg
`default_nettype wire

// File: rtl/bram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter_if
// Description : Request/response channel between one requester and the
//               BRAM arbiter.
//               Request : req_valid, req_ready, req_we[3:0], req_addr[31:0],
//                         req_wdata[31:0]
//               Response: rsp_valid, rsp_ready, rsp_rdata[31:0], rsp_err
//               master  = requester side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_arbiter_if;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface : bram_arbiter_if
`default_nettype wire

// File: rtl/bram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant with a priority pointer.
//               CLK, RSTN      : clock, async active-low reset
//               req[1:0]       : request vector
//               done, done_id  : a transaction owned by done_id completed
//               gnt[1:0]       : one-hot grant (0 when nobody requests)
//               gnt_id         : index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  wire logic       CLK,
  input  wire logic       RSTN,
  input  wire logic [1:0] req,
  input  wire logic       done,
  input  wire logic       done_id,
  output logic      [1:0] gnt,
  output logic            gnt_id
);

  // prio_q names the requester that wins a tie; reset favours m0.
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_id = 1'b0;
    if (req == 2'b11) begin
      gnt_id = prio_q;
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end
    gnt = 2'b00;
    if (req != 2'b00) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

  // The pointer moves only when a response completes, so a stalled
  // transaction cannot shift priority.
  always_comb begin
    prio_d = prio_q;
    if (done) begin
      prio_d = ~done_id;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter
// Description : Shares one single-port BRAM between two requesters, one
//               transaction in flight at a time (IDLE->ISSUE->CAPTURE->RESP).
//               CLK, RSTN : clock, async active-low reset
//               m0, m1    : requester channels (bram_arbiter_if.slave)
//               bram_*0   : BRAM port; bram_Do0 valid one cycle after EN0
//               N         : BRAM word-address width
//               RSP_ERR_EN: flag addresses with bits set at or above N
// Revision    : 1.0 - initial release
// ============================================================================
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned N          = N_DEFAULT,
  parameter bit          RSP_ERR_EN = 1'b1
) (
  input  wire logic        CLK,
  input  wire logic        RSTN,
  bram_arbiter_if.slave    m0,
  bram_arbiter_if.slave    m1,
  output logic [3:0]       bram_WE0,
  output logic             bram_EN0,
  output logic [31:0]      bram_Di0,
  output logic [31:0]      bram_A0,
  input  wire logic [31:0] bram_Do0
);

  localparam logic [31:0] ADDR_MASK = addr_mask(N);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [1:0]  req_vec;
  logic [1:0]  gnt;
  logic        gnt_id;
  logic        arb_done;
  logic        owner_rsp_ready;
  logic        in_resp;
  logic [3:0]  sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  assign req_vec = {m1.req_valid, m0.req_valid};

  rr_arb2 u_rr_arb2 (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .req     (req_vec),
    .done    (arb_done),
    .done_id (owner_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  // Ready is only offered in IDLE, so requests arriving mid-transaction
  // simply wait with valid held high.
  assign m0.req_ready = (state_q == IDLE) && gnt[0];
  assign m1.req_ready = (state_q == IDLE) && gnt[1];

  always_comb begin
    sel_we    = gnt_id ? m1.req_we    : m0.req_we;
    sel_addr  = gnt_id ? m1.req_addr  : m0.req_addr;
    sel_wdata = gnt_id ? m1.req_wdata : m0.req_wdata;
  end

  assign owner_rsp_ready = owner_q ? m1.rsp_ready : m0.rsp_ready;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    arb_done = 1'b0;
    case (state_q)
      IDLE: begin
        // Any grant in IDLE is an accept: ready is exactly that grant.
        if (gnt != 2'b00) begin
          owner_d = gnt_id;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = RSP_ERR_EN && addr_oob(sel_addr, N);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // Writes and rejected accesses return zero data; only a valid
        // read takes the BRAM output.
        if (err_q || (we_q != 4'h0)) begin
          rdata_d = 32'h0;
        end else begin
          rdata_d = bram_Do0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          arb_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // BRAM port is decoded straight from the state register so a reset
  // drops the enable immediately; a rejected address never enables it.
  always_comb begin
    bram_EN0 = 1'b0;
    bram_WE0 = 4'h0;
    bram_A0  = 32'h0;
    bram_Di0 = 32'h0;
    if (state_q == ISSUE) begin
      bram_EN0 = ~err_q;
      bram_WE0 = err_q ? 4'h0 : we_q;
      bram_A0  = addr_q & ADDR_MASK;
      bram_Di0 = wdata_q;
    end
  end

  assign in_resp = (state_q == RESP);

  assign m0.rsp_valid = in_resp && !owner_q;
  assign m0.rsp_rdata = (in_resp && !owner_q) ? rdata_q : 32'h0;
  assign m0.rsp_err   = in_resp && !owner_q && err_q;

  assign m1.rsp_valid = in_resp && owner_q;
  assign m1.rsp_rdata = (in_resp && owner_q) ? rdata_q : 32'h0;
  assign m1.rsp_err   = in_resp && owner_q && err_q;

endmodule : bram_arbiter
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_arbiter
// Description : Scoreboard bench for bram_arbiter with a behavioural BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_arbiter;

  typedef struct {
    int          owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  bram_arbiter_if m0_if ();
  bram_arbiter_if m1_if ();

  logic [1:0]  vld  = 2'b00;
  logic [1:0]  rrdy = 2'b11;
  logic [3:0]  we_a [2];
  logic [31:0] ad   [2];
  logic [31:0] wd   [2];

  assign m0_if.req_valid = vld[0];
  assign m0_if.req_we    = we_a[0];
  assign m0_if.req_addr  = ad[0];
  assign m0_if.req_wdata = wd[0];
  assign m0_if.rsp_ready = rrdy[0];
  assign m1_if.req_valid = vld[1];
  assign m1_if.req_we    = we_a[1];
  assign m1_if.req_addr  = ad[1];
  assign m1_if.req_wdata = wd[1];
  assign m1_if.rsp_ready = rrdy[1];

  logic [1:0]  rdy;
  logic [1:0]  rsp_v;
  logic [1:0]  rsp_e;
  logic [31:0] rsp_d [2];
  assign rdy      = {m1_if.req_ready, m0_if.req_ready};
  assign rsp_v    = {m1_if.rsp_valid, m0_if.rsp_valid};
  assign rsp_e    = {m1_if.rsp_err,   m0_if.rsp_err};
  assign rsp_d[0] = m0_if.rsp_rdata;
  assign rsp_d[1] = m1_if.rsp_rdata;

  logic [3:0]  bram_WE0;
  logic        bram_EN0;
  logic [31:0] bram_Di0;
  logic [31:0] bram_A0;
  logic [31:0] bram_Do0 = 32'h0;

  bram_arbiter #(.N(17), .RSP_ERR_EN(1'b1)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .m0       (m0_if),
    .m1       (m1_if),
    .bram_WE0 (bram_WE0),
    .bram_EN0 (bram_EN0),
    .bram_Di0 (bram_Di0),
    .bram_A0  (bram_A0),
    .bram_Do0 (bram_Do0)
  );

  // Behavioural BRAM: byte-enabled write, registered read, zero output
  // when not enabled. Preloaded once on the first clock edge.
  logic [31:0] mem [0:1023];
  bit          pre_done = 1'b0;
  int          en_cnt   = 0;

  always @(posedge CLK) begin
    if (!pre_done) begin
      mem[0]   <= 32'hCAFE_F00D;
      mem[5]   <= 32'hDEAD_BEEF;
      mem[9]   <= 32'hAAAA_AAAA;
      mem[20]  <= 32'h0BAD_0020;
      mem[21]  <= 32'h0BAD_0021;
      mem[22]  <= 32'h0BAD_0022;
      mem[23]  <= 32'h0BAD_0023;
      mem[30]  <= 32'h0000_0000;
      pre_done <= 1'b1;
    end else if (bram_EN0) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_WE0[b]) mem[bram_A0[9:0]][8*b +: 8] <= bram_Di0[8*b +: 8];
      end
    end
    if (bram_EN0) en_cnt <= en_cnt + 1;
    bram_Do0 <= bram_EN0 ? mem[bram_A0[9:0]] : 32'h0;
  end

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic expect_rsp(input int o, input logic [31:0] r, input logic e);
    exp_t x;
    x.owner = o;
    x.rdata = r;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic raise(input int who, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d);
    we_a[who] = w;
    ad[who]   = a;
    wd[who]   = d;
    vld[who]  = 1'b1;
  endtask

  // Returns #1 after the accepting edge, i.e. in the ISSUE cycle.
  task automatic wait_acc(input int who);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (rdy[who]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK);
    #1;
    vld[who] = 1'b0;
    chk($sformatf("accept_m%0d", who), 32'(ok), 32'd1);
  endtask

  task automatic send(input int who, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d);
    raise(who, w, a, d);
    wait_acc(who);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
    @(posedge CLK);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every response handshake pops the next expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge CLK);
      if (RSTN) begin
        for (int x = 0; x < 2; x++) begin
          if (rsp_v[x] && rrdy[x]) begin
            chk($sformatf("nonowner_rdata_m%0d", 1 - x), rsp_d[1-x], 32'h0);
            chk($sformatf("nonowner_valid_m%0d", 1 - x), 32'(rsp_v[1-x]), 32'd0);
            if (sb.size() == 0) begin
              chk("rsp_unexpected", 32'(sb.size()), 32'd1);
            end else begin
              e = sb.pop_front();
              chk("rsp_owner", 32'(x), 32'(e.owner));
              chk("rsp_rdata", rsp_d[x], e.rdata);
              chk("rsp_err", 32'(rsp_e[x]), 32'(e.err));
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int en_b;
    int bad_v;
    int bad_r;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      we_a[i] = 4'h0;
      ad[i]   = 32'h0;
      wd[i]   = 32'h0;
    end

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_en", 32'(bram_EN0), 32'd0);
    chk("rst_we", 32'(bram_WE0), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_v), 32'd0);
    chk("rst_req_ready", 32'(rdy), 32'd0);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;

    // Single read with timing
    expect_rsp(0, 32'hDEAD_BEEF, 1'b0);
    en_b = en_cnt;
    send(0, 4'h0, 32'd5, 32'h0);
    chk("t1_issue_en", 32'(bram_EN0), 32'd1);
    chk("t1_issue_a0", bram_A0, 32'd5);
    chk("t1_issue_we", 32'(bram_WE0), 32'd0);
    @(posedge CLK);
    #1;
    chk("t1_capture_en", 32'(bram_EN0), 32'd0);
    chk("t1_capture_valid", 32'(rsp_v[0]), 32'd0);
    @(posedge CLK);
    #1;
    chk("t1_resp_valid", 32'(rsp_v[0]), 32'd1);
    drain();
    chk("t1_en_cycles", 32'(en_cnt - en_b), 32'd1);

    // Byte write then read
    expect_rsp(1, 32'h0, 1'b0);
    send(1, 4'b0101, 32'd9, 32'h1122_3344);
    drain();
    chk("t2_mem9", mem[9], 32'hAA22_AA44);
    expect_rsp(1, 32'hAA22_AA44, 1'b0);
    send(1, 4'h0, 32'd9, 32'h0);
    drain();

    // Contention: m1 was served last, so m0 leads and grants alternate
    expect_rsp(0, 32'h0BAD_0020, 1'b0);
    expect_rsp(1, 32'h0BAD_0021, 1'b0);
    expect_rsp(0, 32'h0BAD_0022, 1'b0);
    expect_rsp(1, 32'h0BAD_0023, 1'b0);
    fork
      begin
        send(0, 4'h0, 32'd20, 32'h0);
        send(0, 4'h0, 32'd22, 32'h0);
      end
      begin
        send(1, 4'h0, 32'd21, 32'h0);
        send(1, 4'h0, 32'd23, 32'h0);
      end
    join
    drain();

    // Backpressure with m1 waiting
    rrdy[0] = 1'b0;
    expect_rsp(0, 32'hDEAD_BEEF, 1'b0);
    expect_rsp(1, 32'hAA22_AA44, 1'b0);
    send(0, 4'h0, 32'd5, 32'h0);
    raise(1, 4'h0, 32'd9, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (rsp_v[0]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t4_rsp_seen", 32'(ok), 32'd1);
    bad_v = 0;
    bad_r = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (!rsp_v[0] || rsp_d[0] !== 32'hDEAD_BEEF || rsp_e[0]) bad_v++;
      if (rdy[1]) bad_r++;
    end
    chk("t4_rsp_stable", 32'(bad_v), 32'd0);
    chk("t4_m1_stalled", 32'(bad_r), 32'd0);
    @(posedge CLK);
    #1;
    rrdy[0] = 1'b1;
    wait_acc(1);
    drain();

    // Out of range write and read
    en_b = en_cnt;
    expect_rsp(0, 32'h0, 1'b1);
    send(0, 4'hF, 32'h0002_0000, 32'h1234_5678);
    drain();
    expect_rsp(1, 32'h0, 1'b1);
    send(1, 4'h0, 32'h8000_0005, 32'h0);
    drain();
    chk("t5_no_en", 32'(en_cnt - en_b), 32'd0);
    chk("t5_mem0", mem[0], 32'hCAFE_F00D);

    // Reset during ISSUE
    en_b = en_cnt;
    send(0, 4'hF, 32'd30, 32'h5555_AAAA);
    chk("t6_issue_en", 32'(bram_EN0), 32'd1);
    #2;
    RSTN = 1'b0;
    #1;
    chk("t6_en_drop", 32'(bram_EN0), 32'd0);
    chk("t6_rsp_valid_rst", 32'(rsp_v), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    bad_v = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (rsp_v != 2'b00) bad_v++;
    end
    chk("t6_no_rsp", 32'(bad_v), 32'd0);
    chk("t6_no_bram_cycle", 32'(en_cnt - en_b), 32'd0);
    chk("t6_mem30", mem[30], 32'h0);
    @(posedge CLK);
    #1;
    expect_rsp(0, 32'h0BAD_0020, 1'b0);
    expect_rsp(1, 32'h0BAD_0021, 1'b0);
    fork
      send(0, 4'h0, 32'd20, 32'h0);
      send(1, 4'h0, 32'd21, 32'h0);
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_bram_arbiter
`default_nettype wire

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter: N, default 17, BRAM word-address width; must equal the BRAM's N.
REQ-002 Parameter: RSP_ERR_EN, default 1, enables out-of-range address checking.
REQ-003 The block SHALL have exactly one clock, CLK; every flop is rising-edge.
REQ-004 Reset is RSTN: asynchronous, active-low.
REQ-005 Ports, X = 0,1: name  direction  width  meaning.
- CLK  in  1  clock.
- RSTN  in  1  async active-low reset.
- mX_req_valid  in  1  requester X presents a request.
- mX_req_ready  out  1  request accepted this cycle.
- mX_req_we  in  4  byte write enables; 0 = read.
- mX_req_addr  in  32  word address.
- mX_req_wdata  in  32  write data.
- mX_rsp_valid  out  1  response available.
- mX_rsp_ready  in  1  requester takes the response.
- mX_rsp_rdata  out  32  read data.
- mX_rsp_err  out  1  address out of range.
- bram_WE0  out  4  BRAM byte write enables.
- bram_EN0  out  1  BRAM enable.
- bram_Di0  out  32  BRAM write data.
- bram_A0  out  32  BRAM address.
- bram_Do0  in  32  BRAM read data; valid one cycle after EN0; 0 when EN0 was low.

Function
REQ-006 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP; one transaction in flight at a time.
REQ-007 mX_req_ready SHALL be combinational: 1 only when state = IDLE and X holds the grant.
REQ-008 Grant SHALL be 2-way round-robin.
- Both valid: the requester not served last wins.
- One valid: that requester wins.
- The pointer updates only on response completion.
REQ-009 On accept (valid & ready), the block SHALL register owner, we, addr and wdata, then go IDLE -> ISSUE.
REQ-010 ISSUE SHALL last one cycle and drive the BRAM from the registered fields:
- bram_EN0 = 1; bram_WE0 = we; bram_A0 = {zeros, addr[N-1:0]}; bram_Di0 = wdata.
- Next state is CAPTURE.
REQ-011 CAPTURE SHALL register the response data, then go to RESP:
- read (we = 0): rdata = bram_Do0.
- write: rdata = 32'h0.
REQ-012 RESP SHALL hold the owner's rsp_valid, rsp_rdata and rsp_err stable until rsp_ready; RESP -> IDLE on the cycle rsp_ready = 1.
REQ-013 Latency: accept at edge t -> rsp_valid high from t+3. Minimum spacing between accepts is 4 cycles.
REQ-014 Out-of-range: if RSP_ERR_EN = 1 and addr[31:N] != 0, the block SHALL:
- keep bram_EN0 and bram_WE0 at 0 during ISSUE;
- return rsp_err = 1 and rdata = 0 with the same latency.
REQ-015 Outside ISSUE, bram_EN0, bram_WE0, bram_A0 and bram_Di0 SHALL all be 0.
REQ-016 The non-owner's rsp_valid, rsp_rdata and rsp_err SHALL be 0.
REQ-017 Requests arriving while not in IDLE SHALL stall (ready = 0) and are never dropped.
REQ-018 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-019 On RSTN low, the block SHALL immediately (asynchronously) set:
- state = IDLE, pointer favouring m0;
- all outputs and registered fields to 0.
REQ-020 Reset asserted mid-transaction SHALL abort the transaction with no response; no BRAM enable is issued after reset asserts.

Structure
REQ-021 Package bram_arb_pkg SHALL hold the state encoding constants and the default N.
REQ-022 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant and pointer.

Verification
REQ-023 Single read:
- Stimulus: preload word 5 = 32'hDEADBEEF; m0 reads addr 5.
- Response: EN0 pulses 1 cycle at t+1; m0_rsp_valid at t+3; rdata = 32'hDEADBEEF; err = 0.
REQ-024 Byte write then read:
- Stimulus: m1 writes we = 4'b0101, wdata = 32'h11223344 to a word holding 32'hAAAAAAAA; then reads it.
- Response: rdata = 32'hAA22AA44.
REQ-025 Contention:
- Stimulus: m0 and m1 both hold valid for 4 transactions.
- Response: grants in order m0, m1, m0, m1; no request lost.
REQ-026 Backpressure:
- Stimulus: m0_rsp_ready low 10 cycles in RESP.
- Response: rsp_valid and rdata stable throughout; m1_req_ready stays 0 until release.
REQ-027 Out of range:
- Stimulus: addr 32'h0002_0000, we = 4'hF.
- Response: EN0 never asserted; rsp_err = 1; rdata = 0; memory unchanged.
REQ-028 Reset in ISSUE:
- Stimulus: RSTN pulsed low during ISSUE.
- Response: EN0 drops immediately; no rsp_valid; next request served normally, with m0 winning a tie.
